spi_shift_engine: RTL and testbench

//  SPI master frame engine, directly downstream of the SPI SCLK generator. Drives its tx/rx/enable/reset

---
 rtl/spi_shift_engine.sv | 162 ++++++++++++++++
 tb/tb_spi_shift_engine.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// SPI master frame engine (CPOL=0/CPHA=1): frames CS_N around WIDTH SCLK pulses from an external
// divider, shifting tx data MSB-first after each rise and capturing MISO on each fall.
module spi_shift_engine #(
  parameter int WIDTH           = 8,
  parameter int CS_SETUP_CYCLES = 4,
  parameter int CS_HOLD_CYCLES  = 4
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             cmd_tx_i,
  input  logic             cmd_rx_i,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             sclk_i,
  input  logic             MISO_i,
  output logic             tx_en_o,
  output logic             rx_en_o,
  output logic             sclk_div_en_o,
  output logic             sclk_div_rst_o,
  output logic             CS_N_o,
  output logic             MOSI_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_sclkQ;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bitCnt;
  logic [WIDTH-1:0] r_txSr;
  logic [WIDTH-1:0] r_rxSr;
  logic [WIDTH-1:0] r_rxData;
  logic             r_cmdTx;
  logic             r_cmdRx;
  logic             r_mosi;
  logic             w_accept;
  logic             w_rise;
  logic             w_fall;
  logic [WIDTH-1:0] w_rxNext;

  assign w_accept  = start_i & (cmd_tx_i | cmd_rx_i);
  assign w_rise    = (r_state == ST_SHIFT) &  sclk_i & ~r_sclkQ;
  assign w_fall    = (r_state == ST_SHIFT) & ~sclk_i &  r_sclkQ;
  assign rx_data_o = r_rxData;

  // Written this way so a one-bit frame needs no special-cased slice.
  always_comb begin
    w_rxNext    = r_rxSr << 1;
    w_rxNext[0] = MISO_i;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_SETUP;
      ST_SETUP: if (r_cnt == SETUP_LAST) w_next = ST_SHIFT;
      ST_SHIFT: if (w_fall && (r_bitCnt == BIT_LAST)) w_next = ST_HOLD;
      ST_HOLD:  if (r_cnt == HOLD_LAST) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // The divider sits in reset outside SHIFT, so SCLK always restarts with a full low phase.
  always_comb begin
    tx_en_o        = 1'b0;
    rx_en_o        = 1'b0;
    sclk_div_en_o  = 1'b0;
    sclk_div_rst_o = 1'b1;
    CS_N_o         = 1'b1;
    MOSI_o         = 1'b0;
    busy_o         = (r_state != ST_IDLE);
    done_o         = 1'b0;
    case (r_state)
      ST_SETUP: CS_N_o = 1'b0;
      ST_SHIFT: begin
        CS_N_o         = 1'b0;
        tx_en_o        = r_cmdTx;
        rx_en_o        = r_cmdRx;
        sclk_div_en_o  = 1'b1;
        sclk_div_rst_o = 1'b0;
        MOSI_o         = r_mosi;
      end
      ST_HOLD:  CS_N_o = 1'b0;
      ST_DONE:  done_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sclkQ  <= 1'b0;
      r_cnt    <= '0;
      r_bitCnt <= '0;
      r_txSr   <= '0;
      r_rxSr   <= '0;
      r_rxData <= '0;
      r_cmdTx  <= 1'b0;
      r_cmdRx  <= 1'b0;
      r_mosi   <= 1'b0;
    end else begin
      r_sclkQ <= sclk_i;
      case (r_state)
        ST_IDLE: begin
          r_mosi <= 1'b0;
          if (w_accept) begin
            r_txSr  <= tx_data_i;
            r_rxSr  <= '0;
            r_cmdTx <= cmd_tx_i;
            r_cmdRx <= cmd_rx_i;
          end
        end
        ST_SETUP: begin
          r_bitCnt <= '0;
          r_cnt    <= (r_cnt == SETUP_LAST) ? '0 : r_cnt + CW'(1);
        end
        ST_SHIFT: begin
          if (w_rise && r_cmdTx) begin
            r_mosi <= r_txSr[WIDTH-1];
            r_txSr <= r_txSr << 1;
          end
          if (w_fall) begin
            if (r_cmdRx) r_rxSr <= w_rxNext;
            r_bitCnt <= r_bitCnt + BW'(1);
          end
        end
        ST_HOLD: begin
          r_mosi <= 1'b0;
          r_cnt  <= (r_cnt == HOLD_LAST) ? '0 : r_cnt + CW'(1);
        end
        ST_DONE: begin
          r_mosi <= 1'b0;
          if (r_cmdRx) r_rxData <= r_rxSr;
        end
        default: r_mosi <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: models the SCLK divider and a CPHA=1 slave, and scores MOSI bits,
// received words and CS framing against queued expectations.
module tb_spi_shift_engine;

  localparam int WIDTH = 8;
  localparam int SETUP = 4;
  localparam int HOLD  = 4;
  localparam int HALF  = 2;

  logic             clock = 1'b0;
  logic             resetN = 1'b0;
  logic             start = 1'b0;
  logic             cmdTx = 1'b0;
  logic             cmdRx = 1'b0;
  logic [WIDTH-1:0] txData = '0;
  logic             sclk = 1'b0;
  logic             miso = 1'b0;
  logic             txEn, rxEn, divEn, divRst, csN, mosi, busy, done;
  logic [WIDTH-1:0] rxData;

  spi_shift_engine #(.WIDTH(WIDTH), .CS_SETUP_CYCLES(SETUP), .CS_HOLD_CYCLES(HOLD)) dut (
    .clock_i(clock), .reset_n_i(resetN), .start_i(start), .cmd_tx_i(cmdTx), .cmd_rx_i(cmdRx),
    .tx_data_i(txData), .sclk_i(sclk), .MISO_i(miso), .tx_en_o(txEn), .rx_en_o(rxEn),
    .sclk_div_en_o(divEn), .sclk_div_rst_o(divRst), .CS_N_o(csN), .MOSI_o(mosi),
    .rx_data_o(rxData), .busy_o(busy), .done_o(done)
  );

  always #5 clock = ~clock;

  // Divider model: held low in reset, toggles every HALF clocks while enabled.
  int divCnt = 0;
  always @(posedge clock) begin
    if (divRst) begin
      sclk   <= 1'b0;
      divCnt <= 0;
    end else if (divEn) begin
      if (divCnt == HALF - 1) begin
        divCnt <= 0;
        sclk   <= ~sclk;
      end else begin
        divCnt <= divCnt + 1;
      end
    end
  end

  // Slave presents the next MSB-first bit on each SCLK rise.
  logic [WIDTH-1:0] misoWord = '0;
  int               misoIdx  = WIDTH - 1;
  always @(posedge sclk) begin
    miso = misoWord[misoIdx];
    if (misoIdx > 0) misoIdx = misoIdx - 1;
  end

  int               compared = 0;
  int               mismatched = 0;
  logic             expMosiQ[$];
  logic [WIDTH-1:0] expRxQ[$];

  logic             obsMosi[$];
  int               obsRises, obsFalls, csFallAt, firstRiseAt, lastFallAt, csRiseAt, doneCycles;
  logic             txEnSeen, rxEnSeen, busyAfterDone, timedOut;
  logic [WIDTH-1:0] rxAfterDone;

  task automatic startFrame(input logic tx, input logic rx, input logic [WIDTH-1:0] data,
                            input logic [WIDTH-1:0] slaveWord);
    @(negedge clock);
    start    = 1'b1;
    cmdTx    = tx;
    cmdRx    = rx;
    txData   = data;
    misoWord = slaveWord;
    misoIdx  = WIDTH - 1;
    for (int i = WIDTH - 1; i >= 0; i--) expMosiQ.push_back(tx ? data[i] : 1'b0);
    if (rx) expRxQ.push_back(slaveWord);
  endtask

  // Observes one frame at negedges; returns the cycle after done_o, or at the abort fall.
  task automatic waitFrame(input logic holdStart, input logic [WIDTH-1:0] nextData,
                           input int injectAtRise, input int abortAtFall);
    int   cyc = 0;
    logic prevSclk = 1'b0;
    logic seenCs = 1'b0;
    logic doneSeen = 1'b0;
    logic injecting = 1'b0;
    obsMosi.delete();
    obsRises = 0; obsFalls = 0; csFallAt = -1; firstRiseAt = -1; lastFallAt = -1;
    csRiseAt = -1; doneCycles = 0; txEnSeen = 0; rxEnSeen = 0; busyAfterDone = 1'b1;
    timedOut = 0; rxAfterDone = '0;
    while (1) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        if (holdStart) txData = nextData;
        else           start  = 1'b0;
      end
      if (injecting) begin
        start = 1'b0;
        injecting = 1'b0;
      end
      if (!csN && !seenCs) begin
        seenCs = 1'b1;
        csFallAt = cyc;
      end
      if (txEn) txEnSeen = 1'b1;
      if (rxEn) rxEnSeen = 1'b1;
      if (sclk && !prevSclk) begin
        obsRises++;
        if (obsRises == 1) firstRiseAt = cyc;
        if (obsRises == injectAtRise) begin
          start = 1'b1; cmdTx = 1'b1; cmdRx = 1'b0; txData = 8'hFF;
          injecting = 1'b1;
        end
      end
      if (!sclk && prevSclk) begin
        obsFalls++;
        lastFallAt = cyc;
        obsMosi.push_back(mosi);
        if (obsFalls == abortAtFall) begin
          resetN = 1'b0;
          return;
        end
      end
      prevSclk = sclk;
      if (done) doneCycles++;
      if (seenCs && csN && csRiseAt < 0) csRiseAt = cyc;
      if (doneSeen) begin
        busyAfterDone = busy;
        rxAfterDone   = rxData;
        return;
      end
      if (done) doneSeen = 1'b1;
      if (cyc >= 400) begin
        timedOut = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    compared++;
    if ({csN, mosi, txEn, rxEn, divEn, divRst, busy, done} !== 8'b1000_0100) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b want %b",
               {csN, mosi, txEn, rxEn, divEn, divRst, busy, done}, 8'b1000_0100);
    end
    compared++;
    if (rxData !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_rx_data: got %h want 00", rxData);
    end
    resetN = 1'b1;
  endtask

  task automatic test_tx_frame;
    startFrame(1'b1, 1'b0, 8'hA5, 8'h00);
    waitFrame(1'b0, '0, 0, 0);
    compared++;
    if (timedOut !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL tx_timeout: got %b want 0", timedOut);
    end
    compared++;
    if (obsRises !== WIDTH) begin
      mismatched++;
      $display("[TB] FAIL tx_pulses: got %0d want %0d", obsRises, WIDTH);
    end
    for (int i = 0; i < obsMosi.size(); i++) begin
      logic exp = (expMosiQ.size() > 0) ? expMosiQ.pop_front() : 1'bx;
      compared++;
      if (obsMosi[i] !== exp) begin
        mismatched++;
        $display("[TB] FAIL tx_mosi_bit%0d: got %b want %b", i, obsMosi[i], exp);
      end
    end
    compared++;
    if (doneCycles !== 1) begin
      mismatched++;
      $display("[TB] FAIL tx_done_width: got %0d want 1", doneCycles);
    end
    compared++;
    if (firstRiseAt - csFallAt < SETUP) begin
      mismatched++;
      $display("[TB] FAIL cs_setup: got %0d want >= %0d", firstRiseAt - csFallAt, SETUP);
    end
    compared++;
    if (csRiseAt - lastFallAt !== HOLD + 1) begin
      mismatched++;
      $display("[TB] FAIL cs_hold: got %0d want %0d", csRiseAt - lastFallAt, HOLD + 1);
    end
    compared++;
    if (txEnSeen !== 1'b1 || rxEnSeen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL tx_enables: got tx=%b rx=%b want tx=1 rx=0", txEnSeen, rxEnSeen);
    end
  endtask

  task automatic test_rx_frame;
    logic [WIDTH-1:0] exp;
    startFrame(1'b0, 1'b1, 8'h00, 8'h3C);
    waitFrame(1'b0, '0, 0, 0);
    exp = (expRxQ.size() > 0) ? expRxQ.pop_front() : 'x;
    compared++;
    if (rxAfterDone !== exp) begin
      mismatched++;
      $display("[TB] FAIL rx_data: got %h want %h", rxAfterDone, exp);
    end
    for (int i = 0; i < obsMosi.size(); i++) begin
      logic expBit = (expMosiQ.size() > 0) ? expMosiQ.pop_front() : 1'bx;
      compared++;
      if (obsMosi[i] !== expBit) begin
        mismatched++;
        $display("[TB] FAIL rx_mosi_bit%0d: got %b want %b", i, obsMosi[i], expBit);
      end
    end
    compared++;
    if (txEnSeen !== 1'b0 || rxEnSeen !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rx_enables: got tx=%b rx=%b want tx=0 rx=1", txEnSeen, rxEnSeen);
    end
    compared++;
    if (obsRises !== WIDTH || timedOut !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rx_pulses: got %0d timeout=%b want %0d", obsRises, timedOut, WIDTH);
    end
  endtask

  task automatic test_ignore_start;
    startFrame(1'b1, 1'b0, 8'hC3, 8'h00);
    waitFrame(1'b0, '0, 2, 0);
    for (int i = 0; i < obsMosi.size(); i++) begin
      logic exp = (expMosiQ.size() > 0) ? expMosiQ.pop_front() : 1'bx;
      compared++;
      if (obsMosi[i] !== exp) begin
        mismatched++;
        $display("[TB] FAIL ignore_mosi_bit%0d: got %b want %b", i, obsMosi[i], exp);
      end
    end
    compared++;
    if (busyAfterDone !== 1'b0 || obsRises !== WIDTH) begin
      mismatched++;
      $display("[TB] FAIL ignore_no_queue: got busy=%b pulses=%0d want busy=0 pulses=%0d",
               busyAfterDone, obsRises, WIDTH);
    end
    @(negedge clock);
    start = 1'b1; cmdTx = 1'b0; cmdRx = 1'b0; txData = 8'h77;
    @(negedge clock);
    start = 1'b0;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL no_cmd_busy: got %b want 0", busy);
    end
    @(negedge clock);
    compared++;
    if (busy !== 1'b0 || csN !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL no_cmd_idle: got busy=%b cs_n=%b want busy=0 cs_n=1", busy, csN);
    end
  endtask

  task automatic test_reset_midframe;
    logic [WIDTH-1:0] exp;
    startFrame(1'b1, 1'b1, 8'h96, 8'h5A);
    waitFrame(1'b0, '0, 0, 3);
    #1;
    compared++;
    if ({csN, divRst, divEn, busy, done} !== 5'b11000) begin
      mismatched++;
      $display("[TB] FAIL abort_outputs: got %b want 11000", {csN, divRst, divEn, busy, done});
    end
    compared++;
    if (rxData !== '0 || doneCycles !== 0) begin
      mismatched++;
      $display("[TB] FAIL abort_rx: got rx=%h done=%0d want rx=00 done=0", rxData, doneCycles);
    end
    @(posedge clock);
    #1;
    compared++;
    if (sclk !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_sclk: got %b want 0", sclk);
    end
    expMosiQ.delete();
    expRxQ.delete();
    @(negedge clock);
    resetN = 1'b1;
    startFrame(1'b1, 1'b1, 8'h69, 8'hA6);
    waitFrame(1'b0, '0, 0, 0);
    exp = (expRxQ.size() > 0) ? expRxQ.pop_front() : 'x;
    compared++;
    if (rxAfterDone !== exp) begin
      mismatched++;
      $display("[TB] FAIL after_abort_rx: got %h want %h", rxAfterDone, exp);
    end
    for (int i = 0; i < obsMosi.size(); i++) begin
      logic expBit = (expMosiQ.size() > 0) ? expMosiQ.pop_front() : 1'bx;
      compared++;
      if (obsMosi[i] !== expBit) begin
        mismatched++;
        $display("[TB] FAIL after_abort_mosi_bit%0d: got %b want %b", i, obsMosi[i], expBit);
      end
    end
    compared++;
    if (obsRises !== WIDTH || doneCycles !== 1) begin
      mismatched++;
      $display("[TB] FAIL after_abort_frame: got pulses=%0d done=%0d want %0d/1",
               obsRises, doneCycles, WIDTH);
    end
  endtask

  task automatic test_back_to_back;
    startFrame(1'b1, 1'b0, 8'h81, 8'h00);
    for (int i = WIDTH - 1; i >= 0; i--) expMosiQ.push_back(i[0] ? 1'b0 : 1'b1);
    waitFrame(1'b1, 8'h55, 0, 0);
    compared++;
    if (busyAfterDone !== 1'b0 || obsRises !== WIDTH) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got busy=%b pulses=%0d want busy=0 pulses=%0d",
               busyAfterDone, obsRises, WIDTH);
    end
    for (int i = 0; i < obsMosi.size(); i++) begin
      logic exp = (expMosiQ.size() > 0) ? expMosiQ.pop_front() : 1'bx;
      compared++;
      if (obsMosi[i] !== exp) begin
        mismatched++;
        $display("[TB] FAIL b2b1_mosi_bit%0d: got %b want %b", i, obsMosi[i], exp);
      end
    end
    waitFrame(1'b0, '0, 0, 0);
    compared++;
    if (csFallAt !== 1 || obsRises !== WIDTH || doneCycles !== 1) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got cs_fall=%0d pulses=%0d done=%0d want 1/%0d/1",
               csFallAt, obsRises, doneCycles, WIDTH);
    end
    for (int i = 0; i < obsMosi.size(); i++) begin
      logic exp = (expMosiQ.size() > 0) ? expMosiQ.pop_front() : 1'bx;
      compared++;
      if (obsMosi[i] !== exp) begin
        mismatched++;
        $display("[TB] FAIL b2b2_mosi_bit%0d: got %b want %b", i, obsMosi[i], exp);
      end
    end
    compared++;
    if (expMosiQ.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_leftover: got %0d want 0", expMosiQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_rx_frame();
    test_ignore_start();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
